// File: rtl/i2s_pkg.sv
// Shared I2S constants and receiver state encoding (also used by the playback transmitter).
package i2s_pkg;
  localparam int I2S_BPS       = 24;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_BCLK_HALF = 12;
  localparam int I2S_LRC_HALF  = 768;

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_t;
endpackage

// File: rtl/i2s_rx_if.sv
// Stereo sample-pair valid/ready channel from the I2S receiver to its consumer.
interface i2s_rx_if import i2s_pkg::*; #(
  parameter int BPS = I2S_BPS
) ();
  logic           valid;
  logic           ready;
  logic [BPS-1:0] left;
  logic [BPS-1:0] right;

  modport master (output valid, left, right, input ready);
  modport slave  (input valid, left, right, output ready);
endinterface

// File: rtl/i2s_sync_edge.sv
// N-stage synchroniser for an asynchronous serial-clock-domain input, plus
// one extra flop so rising/falling edges of the synced value can be seen.
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // synchroniser chain followed by the edge-detect history flop
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;
endmodule

// File: rtl/i2s_rx.sv
// I2S record-path receiver: left-justified, MSB-first BPS-bit samples in
// SLOT_BITS-wide slots, delivered as stereo pairs over a valid/ready channel.
module i2s_rx import i2s_pkg::*; #(
  parameter int BPS         = I2S_BPS,
  parameter int SLOT_BITS   = I2S_SLOT_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_en,
  input  logic       in_BCLK,
  input  logic       in_RECLRC,
  input  logic       in_RECDAT,
  i2s_rx_if.master   rx,
  output logic       out_frame_err,
  output logic       out_overrun
);
  localparam int CW = $clog2(SLOT_BITS) + 1;
  localparam logic [CW-1:0] BPS_C  = CW'(BPS);
  localparam logic [CW-1:0] LAST_C = CW'(BPS - 1);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT_BITS);

  logic bclk_rise, bclk_fall_unused, bclk_s_unused;
  logic lrc_rise, lrc_fall, lrc_s_unused;
  logic dat_s, dat_rise_unused, dat_fall_unused;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk (
    .in_clk(in_clk), .in_rst(in_rst), .d(in_BCLK),
    .q(bclk_s_unused), .rise(bclk_rise), .fall(bclk_fall_unused));
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_lrc (
    .in_clk(in_clk), .in_rst(in_rst), .d(in_RECLRC),
    .q(lrc_s_unused), .rise(lrc_rise), .fall(lrc_fall));
  // data goes through the same depth so it lines up with bclk_rise
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_dat (
    .in_clk(in_clk), .in_rst(in_rst), .d(in_RECDAT),
    .q(dat_s), .rise(dat_rise_unused), .fall(dat_fall_unused));

  i2s_state_t      state_q, state_d;
  logic [CW-1:0]   bit_cnt;
  logic [BPS-2:0]  sreg;      // the BPS-th bit is merged in combinationally at capture
  logic [BPS-1:0]  cap_word;
  logic [BPS-1:0]  left_hold;
  logic            lrc_edge, cap, slot_full, ferr_d, load;

  assign lrc_edge  = lrc_rise | lrc_fall;
  assign cap_word  = {sreg, dat_s};
  // the bclk_rise that shifts in the last sample bit of the current slot
  assign cap       = bclk_rise & ~lrc_edge & (bit_cnt == LAST_C);
  assign slot_full = (bit_cnt >= BPS_C);
  assign load      = in_en & (state_q == ST_RIGHT) & cap;

  // bit counter and shifter; an LRC edge restarts the slot and wins over a coincident bclk_rise
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      bit_cnt <= '0;
      sreg    <= '0;
    end else if (lrc_edge) begin
      bit_cnt <= '0;
    end else if (bclk_rise) begin
      if (bit_cnt < BPS_C)  sreg    <= cap_word[BPS-2:0];
      if (bit_cnt < SLOT_C) bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // state register, plus left-sample holding register
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q       <= ST_ALIGN;
      out_frame_err <= 1'b0;
      left_hold     <= '0;
    end else begin
      state_q       <= state_d;
      out_frame_err <= ferr_d;
      if (in_en && state_q == ST_LEFT && cap) left_hold <= cap_word;
    end
  end

  // slot sequencing: a slot shorter than BPS bits or an out-of-order LRC edge forces realignment
  always_comb begin
    state_d = state_q;
    ferr_d  = 1'b0;
    if (!in_en) begin
      state_d = ST_ALIGN;
    end else begin
      case (state_q)
        ST_ALIGN: if (lrc_rise) state_d = ST_LEFT;
        ST_LEFT: begin
          if (lrc_rise) begin
            ferr_d  = 1'b1;
            state_d = ST_ALIGN;
          end else if (lrc_fall) begin
            if (slot_full) state_d = ST_RIGHT;
            else begin
              ferr_d  = 1'b1;
              state_d = ST_ALIGN;
            end
          end
        end
        ST_RIGHT: begin
          if (lrc_rise) begin
            if (slot_full) state_d = ST_LEFT;
            else begin
              ferr_d  = 1'b1;
              state_d = ST_ALIGN;
            end
          end
        end
        default: state_d = ST_ALIGN;
      endcase
    end
  end

  // output pair register: a new pair is dropped only if the held one cannot leave this cycle
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rx.valid    <= 1'b0;
      rx.left     <= '0;
      rx.right    <= '0;
      out_overrun <= 1'b0;
    end else begin
      out_overrun <= 1'b0;
      if (load && !(rx.valid && !rx.ready)) begin
        rx.left  <= left_hold;
        rx.right <= cap_word;
        rx.valid <= 1'b1;
      end else begin
        if (load) out_overrun <= 1'b1;
        if (rx.valid && rx.ready) rx.valid <= 1'b0;
      end
    end
  end
endmodule
